// File: rtl/bytestream_pkg.sv
// Shared types and widths for the byte serializer / deserializer pair.
package bytestream_pkg;

  localparam int BYTE_W       = 8;
  localparam int BYTES_SENT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } ser_state_t;

endpackage

// File: rtl/byte_serializer_fifo.sv
// First-word-fall-through FIFO; push is ignored when full and pop when empty.
module byte_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             push_s;
  logic             pop_s;

  assign full   = (count_r == CNT_FULL);
  assign empty  = (count_r == CNT_ZERO);
  assign count  = count_r;
  assign rdata  = mem_r[rd_ptr_r];
  assign push_s = push && !full;
  assign pop_s  = pop && !empty;

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= CNT_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/byte_serializer.sv
// Buffers bytes from a valid/ready port and shifts them out MSB-first,
// with shift_enable framing each 8-bit burst for the downstream deserializer.
module byte_serializer #(
  parameter int DEPTH = 4,
  parameter int GAP   = 0
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [bytestream_pkg::BYTE_W-1:0]      in_data,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  output logic                                   serial_out,
  output logic                                   shift_enable,
  output logic                                   busy,
  output logic [bytestream_pkg::BYTES_SENT_W-1:0] bytes_sent
);

  import bytestream_pkg::*;

  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  localparam logic [GAP_W-1:0] GAP_ZERO = GAP_W'(0);
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP > 0) ? GAP_W'(GAP - 1) : GAP_W'(0);
  localparam logic [CW-1:0]    CNT_ZERO = CW'(0);

  ser_state_t                state_r, state_s;
  logic [BYTE_W-1:0]         shift_r, shift_s;
  logic [2:0]                bit_cnt_r, bit_cnt_s;
  logic [GAP_W-1:0]          gap_cnt_r, gap_cnt_s;
  logic                      serial_out_r, serial_out_s;
  logic                      shift_enable_r, shift_enable_s;
  logic [BYTES_SENT_W-1:0]   bytes_sent_r;
  logic                      sent_inc_s;
  logic                      load_s;
  logic                      pop_s;
  logic                      push_s;
  logic [BYTE_W-1:0]         fifo_rdata_s;
  logic                      fifo_full_s;
  logic                      fifo_empty_s;
  logic [CW-1:0]             fifo_count_s;

  assign in_ready     = !fifo_full_s;
  assign push_s       = in_valid && !fifo_full_s;
  assign serial_out   = serial_out_r;
  assign shift_enable = shift_enable_r;
  assign bytes_sent   = bytes_sent_r;
  assign busy         = (state_r != IDLE) || (fifo_count_s != CNT_ZERO);

  byte_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (BYTE_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (in_data),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // Next-state, shifter and output decode; a load from the FIFO overrides whatever the state chose.
  always_comb begin
    state_s        = state_r;
    shift_s        = shift_r;
    bit_cnt_s      = bit_cnt_r;
    gap_cnt_s      = gap_cnt_r;
    serial_out_s   = 1'b0;
    shift_enable_s = 1'b0;
    sent_inc_s     = 1'b0;
    load_s         = 1'b0;
    pop_s          = 1'b0;
    case (state_r)
      IDLE: begin
        load_s = !fifo_empty_s;
      end
      SHIFT: begin
        if (bit_cnt_r != 3'd0) begin
          bit_cnt_s      = bit_cnt_r - 3'd1;
          shift_s        = {shift_r[BYTE_W-2:0], 1'b0};
          serial_out_s   = shift_r[BYTE_W-2];
          shift_enable_s = 1'b1;
        end else begin
          sent_inc_s = 1'b1;
          if (GAP == 0) begin
            state_s = IDLE;
            load_s  = !fifo_empty_s;
          end else begin
            state_s   = bytestream_pkg::GAP;
            gap_cnt_s = GAP_LOAD;
          end
        end
      end
      bytestream_pkg::GAP: begin
        if (gap_cnt_r != GAP_ZERO) begin
          gap_cnt_s = gap_cnt_r - GAP_ONE;
        end else begin
          state_s = IDLE;
          load_s  = !fifo_empty_s;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    if (load_s) begin
      pop_s          = 1'b1;
      shift_s        = fifo_rdata_s;
      bit_cnt_s      = 3'd7;
      serial_out_s   = fifo_rdata_s[BYTE_W-1];
      shift_enable_s = 1'b1;
      state_s        = SHIFT;
    end else begin
      pop_s = 1'b0;
    end
  end

  // State and output registers; reset abandons any byte in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= IDLE;
      shift_r        <= '0;
      bit_cnt_r      <= 3'd0;
      gap_cnt_r      <= GAP_ZERO;
      serial_out_r   <= 1'b0;
      shift_enable_r <= 1'b0;
      bytes_sent_r   <= '0;
    end else begin
      state_r        <= state_s;
      shift_r        <= shift_s;
      bit_cnt_r      <= bit_cnt_s;
      gap_cnt_r      <= gap_cnt_s;
      serial_out_r   <= serial_out_s;
      shift_enable_r <= shift_enable_s;
      if (sent_inc_s) begin
        bytes_sent_r <= bytes_sent_r + 16'd1;
      end
    end
  end

endmodule

// File: doc/byte_serializer.md
Name: byte_serializer

Overview:
Upstream feeder for the bytestreamer deserializer.
- Accepts parallel bytes over a valid/ready handshake and buffers them in a small FIFO.
- Shifts each byte out MSB-first on serial_out, with shift_enable high for exactly 8 consecutive cycles per byte.
- serial_out and shift_enable connect directly to the deserializer's serial_in and shift_enable.

Parameters:
DEPTH, 4, FIFO entries; power of 2, minimum 2
GAP, 0, idle cycles forced between consecutive bytes (0 = back-to-back stream)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
in_data  input  8  byte to transmit
in_valid  input  1  in_data valid
in_ready  output  1  FIFO can accept; transfer occurs when in_valid && in_ready at a rising edge
serial_out  output  1  current bit, MSB first
shift_enable  output  1  high while serial_out carries a valid bit
busy  output  1  high when shifting, in a gap, or FIFO non-empty
bytes_sent  output  16  count of fully shifted bytes, wraps 0xFFFF->0

Behaviour:
- Reset (async, immediate): FIFO empty; state IDLE; bit counter 0; serial_out=0; shift_enable=0; bytes_sent=0; busy=0; in_ready=1 once rst deasserts.
- in_ready = !fifo_full, decoded from registered count; no combinational path from in_valid.
- Blocked data: in_valid while !in_ready is held off, not dropped, not flagged. in_data has no meaning when in_valid=0.
- serial_out, shift_enable and bytes_sent are registered outputs.
- FSM states: IDLE, SHIFT, GAP.
- IDLE:
  - If FIFO non-empty at an edge: pop head into shift register, bit counter = 7.
  - serial_out = head[7] and shift_enable = 1 after that edge; go to SHIFT.
- SHIFT:
  - Each edge: bit counter decrements and serial_out takes the next lower bit.
  - At the edge leaving bit 0: bytes_sent += 1.
  - Then, if GAP=0 and FIFO non-empty: pop next byte in that same edge. serial_out = new[7], shift_enable stays 1, no bubble.
  - Else if GAP>0: go to GAP, shift_enable=0, serial_out=0.
  - Else: go to IDLE, shift_enable=0, serial_out=0.
- GAP: count GAP cycles with shift_enable=0, then behave as IDLE.
- Latency: byte accepted at edge N into an empty FIFO with state IDLE -> bit7 visible after edge N+1. Bits 7..0 occupy cycles N+1..N+8 with shift_enable=1. shift_enable low after edge N+9 if no further data.
- FIFO push and pop in the same edge are both honoured, including count=1 (push+pop leaves count=1) and full (pop occurs, push is blocked by in_ready=0).
- FIFO pointers wrap modulo DEPTH; count is width clog2(DEPTH)+1.
- busy = (state != IDLE) || fifo_count != 0.
- Reset mid-byte: the partial byte is abandoned, shift_enable drops immediately, and the FIFO contents are discarded. The downstream deserializer must also be reset to realign.

Decomposition:
- Package bytestream_pkg holds:
  - BYTE_W = 8.
  - ser_state_t enum {IDLE, SHIFT, GAP}.
  - BYTES_SENT_W = 16.
  - The deserializer reuses BYTE_W from this package.
- Sub-module byte_fifo, parameterised by DEPTH and WIDTH:
  - Ports: clk, rst, push, pop, wdata, rdata (head, first-word-fall-through), full, empty, count.
  - Top level holds the FSM, shift register, bit counter, gap counter and bytes_sent.

Test Plan:
- Single byte 0xA5, GAP=0 -> serial_out 1,0,1,0,0,1,0,1 on 8 consecutive shift_enable=1 cycles starting one cycle after acceptance; bytes_sent=1; busy falls the cycle after the last bit.
- Back-to-back 0xA5, 0x3C, GAP=0 -> 16 contiguous shift_enable=1 cycles, bits 10100101 00111100. Loopback into bytestreamer reports parallel_out 0xA5 then 0x3C with byte_ready.
- Fill: push 5 bytes without draining while state is SHIFT, DEPTH=4 -> in_ready=0 after 4th FIFO entry, 5th held until first pop, no byte lost or reordered; bytes_sent=5 at end.
- GAP=2 with 0x3C, 0xFF queued -> exactly 2 cycles shift_enable=0 between byte 0x3C's last bit and 0xFF's first bit.
- Assert rst at bit 3 of 0xA5 with 2 bytes queued -> shift_enable=0, serial_out=0, busy=0, bytes_sent=0, in_ready=1 immediately. After release, new byte 0x81 shifts cleanly as 1,0,0,0,0,0,0,1.
- Push and pop same edge at count=1 -> count remains 1; ordering preserved for sequence 0x01, 0x02, 0x03.
